dpwm_duty_sched: RTL
====================

DPWM_DUTY_SCHED -- requirements
Module: dpwm_duty_sched

Interface
REQ-001 SHALL have parameter DMIN, default 2: minimum integer duty, in counts.
REQ-002 SHALL have parameter DMAX, default 53: maximum integer duty; 53 + dead time 5 = 58, the low-side cutoff.
REQ-003 SHALL have parameter SS_STEP, default 1: soft-start increment per period, in 1/8-count units.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 enable  in  1  run request (level).
REQ-007 fault  in  1  fault request (level); highest priority.
REQ-008 period_start  in  1  one-cycle pulse when the DPWM counter is at 63 (last cycle of the period).
REQ-009 cmd_duty  in  9  duty command, unsigned: [8:3] integer counts, [2:0] eighths.
REQ-010 cmd_valid  in  1  cmd_duty is valid.
REQ-011 cmd_ready  out  1  block accepts a command this cycle.
REQ-012 d_n_out  out  6  duty word to the DPWM.
REQ-013 pwm_en  out  1  DPWM gate drive enable.
REQ-014 ss_done  out  1  soft-start complete.
REQ-015 state  out  2  FSM state: IDLE=0, SOFT=1, RUN=2, FAULT=3.

Function
REQ-016 SHALL accept a command on cmd_valid & cmd_ready into a pending register.
REQ-017 cmd_ready SHALL be 1 only in SOFT or RUN with no pending command; it SHALL be 0 from acceptance until the pending command is applied.
REQ-018 The accepted command SHALL be clamped to [DMIN<<3, DMAX<<3] and SHALL become the target at the next period_start.
REQ-019 IDLE -> SOFT when enable=1 and fault=0; the effective duty eff (9-bit) SHALL load DMIN<<3 on entry.
REQ-020 In SOFT, at each period_start, eff SHALL become min(eff+SS_STEP, target); the addition SHALL be 10-bit so it never wraps.
REQ-021 SOFT -> RUN and ss_done=1 on the period_start where eff reaches target; if target < eff, eff SHALL load target and the FSM SHALL go to RUN on that period_start.
REQ-022 In RUN, eff SHALL equal the target, updated only at period_start.
REQ-023 In SOFT or RUN, enable=0 SHALL cause IDLE at the next period_start, with pwm_en, ss_done and d_n_out cleared there (graceful stop, no truncated period).
REQ-024 In any state, fault=1 SHALL cause FAULT on the next clock edge, regardless of period_start; in FAULT, pwm_en=0, d_n_out=0, ss_done=0, pending cleared, cmd_ready=0.
REQ-025 FAULT -> IDLE only when fault=0 and enable=0.
REQ-026 d_n_out and pwm_en SHALL update only on period_start edges (except fault and reset), so the DPWM sees a stable word for a whole period.
REQ-027 pwm_en SHALL be 1 from the first period_start handled in SOFT; d_n_out at that edge SHALL be derived from DMIN<<3.
REQ-028 If period_start and command acceptance coincide, the new command SHALL wait for the following period_start.
REQ-029 If fault and period_start coincide, fault SHALL win.

Reset
REQ-030 While rst=0 at a clock edge, all of the following SHALL be reset: state=IDLE, d_n_out=0, pwm_en=0, ss_done=0, cmd_ready=0, eff=0, target=DMIN<<3, pending empty, dither phase=0.
REQ-031 Reset mid-period SHALL abort immediately, with no graceful stop.

Configuration
REQ-032 With DPWM_DITHER_EN defined:
- a 3-bit phase counter SHALL increment at each period_start;
- d_n_out SHALL be eff[8:3] + (eff[2:0] > bitrev(phase)), saturated at DMAX.
REQ-033 Without DPWM_DITHER_EN: d_n_out SHALL be eff[8:3], the phase counter SHALL be absent, and fraction bits SHALL be ignored.

Structure
REQ-034 Package dpwm_pkg SHALL hold the state encoding, DEADTIME=5, PERIOD_LAST=63, DUTY_W=9, and the DMIN/DMAX defaults.
REQ-035 Sub-module dpwm_dither_gen SHALL hold the phase counter and the fractional compare; the top SHALL hold the FSM, the handshake and the clamp.

Verification
REQ-036 Reset release, enable=1, target 20.0 (cmd 160), SS_STEP=8 -> d_n_out 2,3,...,20 on successive periods, then RUN and ss_done=1.
REQ-037 cmd_duty 0x1FF (63.875) -> clamped to 53; cmd 0 -> d_n_out 2.
REQ-038 Dither on, cmd 84 (10.5) in RUN -> d_n_out 11 in exactly 4 of every 8 periods, else 10; dither off -> always 10.
REQ-039 fault asserted mid-period in RUN -> next cycle pwm_en=0, d_n_out=0, state=3; fault=0 with enable=1 -> stays FAULT; then enable=0 -> IDLE.
REQ-040 Two back-to-back cmd_valid -> second held (cmd_ready=0) until the first is applied at period_start; enable=0 mid-period -> pwm_en clears exactly at the next period_start.

Source files
------------

// File: rtl/dpwm_pkg.sv
// Shared encodings, widths and defaults for the DPWM duty scheduler.
package dpwm_pkg;

  localparam int unsigned DUTY_W      = 9;
  localparam int unsigned FRAC_W      = 3;
  localparam int unsigned INT_W       = DUTY_W - FRAC_W;
  localparam int unsigned DEADTIME    = 5;
  localparam int unsigned PERIOD_LAST = 63;
  localparam int unsigned DMIN_DEF    = 2;
  localparam int unsigned DMAX_DEF    = 53;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SOFT  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  // Bit-reversed phase spreads the dither pulses evenly across the 8-period cycle.
  function automatic logic [FRAC_W-1:0] bitrev3(input logic [FRAC_W-1:0] v);
    return {v[0], v[1], v[2]};
  endfunction

endpackage

// File: rtl/dpwm_dither_gen.sv
// Integer duty word from the effective duty; adds fractional dithering when
// DPWM_DITHER_EN is defined, otherwise the fraction bits are dropped.
module dpwm_dither_gen
  import dpwm_pkg::*;
#(
  parameter int unsigned DMAX = DMAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              period_start,
  input  logic [DUTY_W-1:0] eff,
  output logic [INT_W-1:0]  duty_c
);

  logic [INT_W:0] sum_c;

`ifdef DPWM_DITHER_EN
  logic [FRAC_W-1:0] phase_q;
  logic              bump_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= '0;
    end else if (period_start) begin
      phase_q <= phase_q + FRAC_W'(1);
    end
  end

  assign bump_c = eff[FRAC_W-1:0] > bitrev3(phase_q);
  assign sum_c  = {1'b0, eff[DUTY_W-1:FRAC_W]} + (INT_W+1)'(bump_c);
`else
  // No phase state in this build; clock, reset, strobe and fraction are dropped.
  logic unused_c;
  assign unused_c = ^{clk, rst, period_start, eff[FRAC_W-1:0]};
  assign sum_c    = {1'b0, eff[DUTY_W-1:FRAC_W]};
`endif

  assign duty_c = (sum_c > (INT_W+1)'(DMAX)) ? INT_W'(DMAX) : sum_c[INT_W-1:0];

endmodule

// File: rtl/dpwm_duty_sched.sv
// DPWM duty scheduler: command handshake, clamp, soft-start ramp and fault/stop FSM.
// Fractional dithering is enabled with DPWM_DITHER_EN.
module dpwm_duty_sched
  import dpwm_pkg::*;
#(
  parameter int unsigned DMIN    = DMIN_DEF,
  parameter int unsigned DMAX    = DMAX_DEF,
  parameter int unsigned SS_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fault,
  input  logic              period_start,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic [INT_W-1:0]  d_n_out,
  output logic              pwm_en,
  output logic              ss_done,
  output logic [1:0]        state
);

  localparam int unsigned SUM_W    = DUTY_W + 1;
  // Never let the duty eat into the dead time before the period wraps.
  localparam int unsigned DMAX_CUT = (DMAX + DEADTIME > PERIOD_LAST) ? (PERIOD_LAST - DEADTIME) : DMAX;
  localparam logic [DUTY_W-1:0] LO_Q = DUTY_W'(DMIN << FRAC_W);
  localparam logic [DUTY_W-1:0] HI_Q = DUTY_W'(DMAX_CUT << FRAC_W);

  state_t            state_q, state_n;
  logic [DUTY_W-1:0] eff_q, eff_n;
  logic [DUTY_W-1:0] target_q, target_n;
  logic [DUTY_W-1:0] pend_q, pend_n;
  logic              pend_vld_q, pend_vld_n;
  logic [INT_W-1:0]  d_q, d_n;
  logic              pwm_en_q, pwm_en_n;
  logic              ss_done_q, ss_done_n;
  logic              rdy_q, rdy_n;

  logic              accept_c;
  logic [DUTY_W-1:0] clamp_c;
  logic [DUTY_W-1:0] tgt_c;
  logic [SUM_W-1:0]  step_sum_c;
  logic [INT_W-1:0]  duty_c;

  dpwm_dither_gen #(.DMAX(DMAX_CUT)) u_dither (
    .clk          (clk),
    .rst          (rst),
    .period_start (period_start),
    .eff          (eff_q),
    .duty_c       (duty_c)
  );

  assign accept_c   = cmd_valid & rdy_q;
  assign clamp_c    = (cmd_duty < LO_Q) ? LO_Q : ((cmd_duty > HI_Q) ? HI_Q : cmd_duty);
  // A pending command becomes the target on the same period_start it is applied.
  assign tgt_c      = (period_start && pend_vld_q) ? pend_q : target_q;
  assign step_sum_c = {1'b0, eff_q} + SUM_W'(SS_STEP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      eff_q      <= '0;
      target_q   <= LO_Q;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      d_q        <= '0;
      pwm_en_q   <= 1'b0;
      ss_done_q  <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_n;
      eff_q      <= eff_n;
      target_q   <= target_n;
      pend_q     <= pend_n;
      pend_vld_q <= pend_vld_n;
      d_q        <= d_n;
      pwm_en_q   <= pwm_en_n;
      ss_done_q  <= ss_done_n;
      rdy_q      <= rdy_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    eff_n      = eff_q;
    target_n   = target_q;
    pend_n     = pend_q;
    pend_vld_n = pend_vld_q;
    d_n        = d_q;
    pwm_en_n   = pwm_en_q;
    ss_done_n  = ss_done_q;

    if (fault) begin
      state_n    = FAULT;
      eff_n      = '0;
      pend_vld_n = 1'b0;
      d_n        = '0;
      pwm_en_n   = 1'b0;
      ss_done_n  = 1'b0;
    end else begin
      if (period_start && pend_vld_q) begin
        target_n   = pend_q;
        pend_vld_n = 1'b0;
      end
      // Acceptance on a period_start edge waits for the following period_start.
      if (accept_c) begin
        pend_n     = clamp_c;
        pend_vld_n = 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (enable) begin
            state_n = SOFT;
            eff_n   = LO_Q;
          end
        end
        SOFT, RUN: begin
          if (period_start) begin
            if (!enable) begin
              state_n   = IDLE;
              d_n       = '0;
              pwm_en_n  = 1'b0;
              ss_done_n = 1'b0;
            end else begin
              pwm_en_n = 1'b1;
              d_n      = duty_c;
              if (state_q == RUN) begin
                eff_n = tgt_c;
              end else if (step_sum_c >= {1'b0, tgt_c}) begin
                eff_n     = tgt_c;
                state_n   = RUN;
                ss_done_n = 1'b1;
              end else begin
                eff_n = step_sum_c[DUTY_W-1:0];
              end
            end
          end
        end
        FAULT: begin
          if (!enable) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    rdy_n = ((state_n == SOFT) || (state_n == RUN)) && !pend_vld_n;
  end

  assign cmd_ready = rdy_q;
  assign d_n_out   = d_q;
  assign pwm_en    = pwm_en_q;
  assign ss_done   = ss_done_q;
  assign state     = state_q;

endmodule
